// File: rtl/spi_bridge_pkg.sv
// Shared types and helpers for the SPI-slave to strobe-bus bridge.
package spi_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HDR   = 3'd1,
    WR    = 3'd2,
    RD_PF = 3'd3,
    RD    = 3'd4
  } state_e;

  // Widest word the byte-order helper handles; callers zero-extend into it.
  localparam int unsigned SWAP_MAX_W = 64;

  // Reverse the byte order of the low data_w bits of d (data_w a multiple of 8).
  // Both loop indices are constants so every slice is static.
  function automatic logic [SWAP_MAX_W-1:0] byte_swap(input logic [SWAP_MAX_W-1:0] d,
                                                      input int unsigned data_w);
    logic [SWAP_MAX_W-1:0] r;
    int unsigned           nb;
    nb = data_w / 8;
    r  = '0;
    for (int unsigned i = 0; i < SWAP_MAX_W / 8; i++) begin
      for (int unsigned j = 0; j < SWAP_MAX_W / 8; j++) begin
        if ((i < nb) && (j == nb - 1 - i)) r[8*i +: 8] = d[8*j +: 8];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser for one asynchronous input, with single-cycle
// rise/fall pulses derived from the synchronised level.
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q, sync_q, prev_q;

  // Metastability chain plus one history flop for edge detection.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
      prev_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign q_o    = sync_q;
  assign rise_o = sync_q & ~prev_q;
  assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/spi_bus_bridge.sv
// SPI slave (oversampled in clk) decoding a {addr, RnW} header, then running
// single or burst writes/reads on a one-cycle strobe bus. Reads are
// prefetched one word ahead so MISO never waits on the bus.
module spi_bus_bridge
  import spi_bridge_pkg::*;
#(
  parameter int unsigned ADDR_W    = 15,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned BYTE_SWAP = 1,
  parameter int unsigned CPOL      = 1,
  parameter int unsigned AUTO_INC  = 1,
  parameter int unsigned RD_LAT    = 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              sck,
  input  logic              ss,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  output logic              bus_we,
  output logic              bus_re,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              abort
);

  // Header is {addr, RnW}, so ADDR_W+1 must equal DATA_W.
  localparam int unsigned       CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_W - 1);
  localparam logic [2:0]        LAT      = 3'(RD_LAT);
  localparam logic              SCK_IDLE = (CPOL != 0);

  // Convert between wire order and bus order (self-inverse).
  function automatic logic [DATA_W-1:0] wire_order(input logic [DATA_W-1:0] d);
    if (BYTE_SWAP != 0) return DATA_W'(byte_swap(SWAP_MAX_W'(d), DATA_W));
    else                return d;
  endfunction

  logic sck_s, sck_rise, sck_fall;
  logic ss_s, ss_rise, ss_fall;
  logic mosi_meta_q, mosi_s;
  logic unused_sck_lvl;

  spi_sync_edge #(.RST_VAL(SCK_IDLE)) u_sync_sck (
    .clk_i(clk), .rst_ni(resetn), .d_i(sck),
    .q_o(sck_s), .rise_o(sck_rise), .fall_o(sck_fall)
  );

  spi_sync_edge #(.RST_VAL(1'b1)) u_sync_ss (
    .clk_i(clk), .rst_ni(resetn), .d_i(ss),
    .q_o(ss_s), .rise_o(ss_rise), .fall_o(ss_fall)
  );

  assign unused_sck_lvl = sck_s;

  // MOSI only needs the level; it is stable around the SCK rising edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mosi_meta_q <= 1'b0;
      mosi_s      <= 1'b0;
    end else begin
      mosi_meta_q <= mosi;
      mosi_s      <= mosi_meta_q;
    end
  end

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [DATA_W-2:0]   rx_q, rx_d;
  logic [DATA_W-1:0]   tx_q, tx_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                we_q, we_d, re_q, re_d, abort_q, abort_d;
  logic                pf_busy_q, pf_busy_d;
  logic [2:0]          pf_cnt_q, pf_cnt_d;
  logic [DATA_W-1:0]   pf_data_q, pf_data_d;

  logic [DATA_W-1:0]   rx_next, word_in, rd_word;
  logic                word_done, pf_done;

  // State and datapath registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      rx_q      <= '0;
      tx_q      <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      re_q      <= 1'b0;
      abort_q   <= 1'b0;
      pf_busy_q <= 1'b0;
      pf_cnt_q  <= '0;
      pf_data_q <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      rx_q      <= rx_d;
      tx_q      <= tx_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      re_q      <= re_d;
      abort_q   <= abort_d;
      pf_busy_q <= pf_busy_d;
      pf_cnt_q  <= pf_cnt_d;
      pf_data_q <= pf_data_d;
    end
  end

  // Next-state: header decode, write strobes, prefetch tracking, TX shifting.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    rx_d      = rx_q;
    tx_d      = tx_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = 1'b0;
    re_d      = 1'b0;
    abort_d   = 1'b0;
    pf_busy_d = pf_busy_q;
    pf_cnt_d  = pf_cnt_q;
    pf_data_d = pf_data_q;

    rx_next   = {rx_q, mosi_s};
    word_in   = wire_order(rx_next);
    rd_word   = wire_order(bus_rdata);
    word_done = sck_rise && (bit_cnt_q == LAST_BIT);
    pf_done   = pf_busy_q && (pf_cnt_q == LAT);

    // Read latency counter: cycle k after the strobe has pf_cnt == k.
    if (re_q) begin
      pf_busy_d = 1'b1;
      pf_cnt_d  = 3'd1;
    end else if (pf_busy_q) begin
      if (pf_done) begin
        pf_busy_d = 1'b0;
        pf_data_d = rd_word;
      end else begin
        pf_cnt_d = pf_cnt_q + 3'd1;
      end
    end

    // Post-write address advance; bus_addr held steady during the strobe.
    if (we_q && (AUTO_INC != 0)) addr_d = addr_q + ADDR_W'(1);

    case (state_q)
      IDLE: begin
        if (ss_fall) begin
          state_d   = HDR;
          bit_cnt_d = '0;
        end
      end
      HDR, WR: begin
        if (sck_rise) begin
          rx_d      = rx_next[DATA_W-2:0];
          bit_cnt_d = word_done ? '0 : bit_cnt_q + CNT_W'(1);
          if (word_done && (state_q == HDR)) begin
            addr_d = word_in[DATA_W-1:1];
            if (word_in[0]) begin
              state_d = RD_PF;
              re_d    = 1'b1;
            end else begin
              state_d = WR;
            end
          end
          if (word_done && (state_q == WR)) begin
            we_d    = 1'b1;
            wdata_d = word_in;
          end
        end
      end
      RD_PF: begin
        if (pf_done) begin
          tx_d    = rd_word;
          state_d = RD;
        end
      end
      RD: begin
        // Falls before the first sample of a word (mode 3 lead-in, or the
        // trailing fall in mode 0) must not shift, hence the bit_cnt guard.
        if (sck_fall && (bit_cnt_q != '0)) begin
          tx_d = {tx_q[DATA_W-2:0], 1'b0};
          if (bit_cnt_q == CNT_W'(1)) begin
            re_d   = 1'b1;
            addr_d = (AUTO_INC != 0) ? addr_q + ADDR_W'(1) : addr_q;
          end
        end
        if (sck_rise) begin
          bit_cnt_d = word_done ? '0 : bit_cnt_q + CNT_W'(1);
          if (word_done) tx_d = pf_data_q;
        end
      end
      default: state_d = IDLE;
    endcase

    // End of transfer wins over everything; partial words are dropped.
    if (ss_rise && (state_q != IDLE)) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
      abort_d   = (bit_cnt_q != '0);
      we_d      = 1'b0;
      re_d      = 1'b0;
      pf_busy_d = 1'b0;
      tx_d      = '0;
    end
  end

  assign miso      = tx_q[DATA_W-1];
  assign miso_oe   = ~ss_s;
  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;
  assign bus_we    = we_q;
  assign bus_re    = re_q;
  assign abort     = abort_q;

endmodule

// File: tb/tb_spi_bus_bridge.sv
// Directed bench: SPI mode 3 master, strobe-bus monitor and a fixed-latency
// read model. A second instance with AUTO_INC=0 shares the SPI wires.
module tb_spi_bus_bridge;

  localparam int HALF = 6;

  logic        clk, resetn, sck, ss, mosi;
  logic        miso, miso_oe, bus_we, bus_re, abort;
  logic [14:0] bus_addr;
  logic [15:0] bus_wdata;
  logic [15:0] bus_rdata = 16'hDEAD;
  logic        miso2, miso_oe2, bus_we2, bus_re2, abort2;
  logic [14:0] bus_addr2;
  logic [15:0] bus_wdata2;
  logic [15:0] bus_rdata2;

  assign bus_rdata2 = 16'h0000;

  spi_bus_bridge #(.ADDR_W(15), .DATA_W(16), .BYTE_SWAP(1), .CPOL(1), .AUTO_INC(1), .RD_LAT(2)) dut (
    .clk(clk), .resetn(resetn), .sck(sck), .ss(ss), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_we(bus_we), .bus_re(bus_re), .bus_rdata(bus_rdata), .abort(abort)
  );

  spi_bus_bridge #(.ADDR_W(15), .DATA_W(16), .BYTE_SWAP(1), .CPOL(1), .AUTO_INC(0), .RD_LAT(2)) dut_fix (
    .clk(clk), .resetn(resetn), .sck(sck), .ss(ss), .mosi(mosi),
    .miso(miso2), .miso_oe(miso_oe2), .bus_addr(bus_addr2), .bus_wdata(bus_wdata2),
    .bus_we(bus_we2), .bus_re(bus_re2), .bus_rdata(bus_rdata2), .abort(abort2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: run did not finish, observed timeout required finish");
    $fatal(1);
  end

  // Bus monitor and read model, sampled mid-cycle.
  logic [14:0] we_a[$], re_a[$], we2_a[$];
  logic [15:0] we_d[$], we2_d[$];
  int          n_abort = 0, n_both = 0;
  int          rd_mode = 0;
  logic        s1_v = 1'b0, s2_v = 1'b0;
  logic [15:0] s1_d = 16'h0, s2_d = 16'h0;

  always @(negedge clk) begin
    if (bus_we) begin we_a.push_back(bus_addr); we_d.push_back(bus_wdata); end
    if (bus_re) re_a.push_back(bus_addr);
    if (bus_we2) begin we2_a.push_back(bus_addr2); we2_d.push_back(bus_wdata2); end
    if (abort) n_abort++;
    if (bus_we && bus_re) n_both++;
    // Data is valid only in the cycle RD_LAT=2 after the strobe.
    s1_v      <= bus_re;
    s1_d      <= (rd_mode != 0) ? {1'b0, bus_addr} : 16'hBEEF;
    s2_v      <= s1_v;
    s2_d      <= s1_d;
    bus_rdata <= s2_v ? s2_d : 16'hDEAD;
  end

  int n_vec = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic spi_bit(input logic b, output logic r);
    sck  = 1'b0;
    mosi = b;
    repeat (HALF) @(negedge clk);
    r   = miso;
    sck = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic spi_byte(input logic [7:0] b, output logic [7:0] r);
    logic rb;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(b[i], rb);
      r[i] = rb;
    end
  endtask

  task automatic ss_start();
    ss = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic ss_end();
    repeat (4) @(negedge clk);
    ss = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    logic [7:0]  r0, r1, r2, r3;
    logic        rb;
    logic [15:0] v;
    int we0, we20, re0, ab0;

    resetn = 1'b0; sck = 1'b1; ss = 1'b1; mosi = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_miso",  {31'd0, miso},    32'd0);
    chk("rst_oe",    {31'd0, miso_oe}, 32'd0);
    chk("rst_addr",  {17'd0, bus_addr},  32'd0);
    chk("rst_wdata", {16'd0, bus_wdata}, 32'd0);
    chk("rst_we",    {31'd0, bus_we},  32'd0);
    chk("rst_re",    {31'd0, bus_re},  32'd0);
    chk("rst_abort", {31'd0, abort},   32'd0);
    resetn = 1'b1;
    repeat (4) @(negedge clk);

    // Single write 0x1234 @ 0x4000: header 0x8000 -> wire 00 80, data 34 12.
    we0 = we_a.size(); ab0 = n_abort;
    ss_start();
    spi_byte(8'h00, r0); spi_byte(8'h80, r0); spi_byte(8'h34, r0); spi_byte(8'h12, r0);
    ss_end();
    chk("wr1_count", we_a.size() - we0, 32'd1);
    chk("wr1_addr",  {17'd0, we_a[we0]}, 32'h4000);
    chk("wr1_data",  {16'd0, we_d[we0]}, 32'h1234);
    chk("wr1_abort", n_abort - ab0, 32'd0);

    // Burst write of 18 words @ 0x4000, data 0xA500+k.
    we0 = we_a.size(); we20 = we2_a.size();
    ss_start();
    spi_byte(8'h00, r0); spi_byte(8'h80, r0);
    for (int k = 0; k < 18; k++) begin
      v = 16'hA500 + 16'(k);
      spi_byte(v[7:0], r0); spi_byte(v[15:8], r0);
    end
    ss_end();
    chk("brst_count",     we_a.size() - we0, 32'd18);
    chk("brst_fix_count", we2_a.size() - we20, 32'd18);
    for (int k = 0; k < 18; k++) begin
      chk($sformatf("brst_addr%0d", k),     {17'd0, we_a[we0+k]},   32'h4000 + k);
      chk($sformatf("brst_data%0d", k),     {16'd0, we_d[we0+k]},   32'hA500 + k);
      chk($sformatf("brst_fix_addr%0d", k), {17'd0, we2_a[we20+k]}, 32'h4000);
      chk($sformatf("brst_fix_data%0d", k), {16'd0, we2_d[we20+k]}, 32'hA500 + k);
    end

    // Read @ 0x1000 (header 0x2001 -> wire 01 20); model returns 0xBEEF.
    // Clocking one word also issues the speculative prefetch of 0x1001.
    rd_mode = 0; re0 = re_a.size(); ab0 = n_abort;
    chk("rd_oe_idle", {31'd0, miso_oe}, 32'd0);
    ss_start();
    chk("rd_oe_sel", {31'd0, miso_oe}, 32'd1);
    spi_byte(8'h01, r0); spi_byte(8'h20, r0);
    spi_byte(8'h00, r0); spi_byte(8'h00, r1);
    ss_end();
    chk("rd_oe_desel", {31'd0, miso_oe}, 32'd0);
    chk("rd_byte0",    {24'd0, r0}, 32'hEF);
    chk("rd_byte1",    {24'd0, r1}, 32'hBE);
    chk("rd_re_count", re_a.size() - re0, 32'd2);
    chk("rd_re_addr0", {17'd0, re_a[re0]},   32'h1000);
    chk("rd_re_addr1", {17'd0, re_a[re0+1]}, 32'h1001);
    chk("rd_abort",    n_abort - ab0, 32'd0);

    // Burst read from 0x7FFF (header 0xFFFF), data = address, wraps to 0.
    rd_mode = 1; re0 = re_a.size();
    ss_start();
    spi_byte(8'hFF, r0); spi_byte(8'hFF, r0);
    spi_byte(8'h00, r0); spi_byte(8'h00, r1); spi_byte(8'h00, r2); spi_byte(8'h00, r3);
    ss_end();
    chk("brd_w0_lo", {24'd0, r0}, 32'hFF);
    chk("brd_w0_hi", {24'd0, r1}, 32'h7F);
    chk("brd_w1_lo", {24'd0, r2}, 32'h00);
    chk("brd_w1_hi", {24'd0, r3}, 32'h00);
    chk("brd_re_count", re_a.size() - re0, 32'd3);
    chk("brd_re_addr0", {17'd0, re_a[re0]},   32'h7FFF);
    chk("brd_re_addr1", {17'd0, re_a[re0+1]}, 32'h0000);
    chk("brd_re_addr2", {17'd0, re_a[re0+2]}, 32'h0001);

    // SS raised after 9 data bits of a write: no strobe, one abort.
    we0 = we_a.size(); ab0 = n_abort;
    ss_start();
    spi_byte(8'h00, r0); spi_byte(8'h80, r0);
    spi_byte(8'h55, r0); spi_bit(1'b1, rb);
    ss_end();
    chk("abt_we",    we_a.size() - we0, 32'd0);
    chk("abt_pulse", n_abort - ab0, 32'd1);

    // Follow-up write 0x00AA @ 0x0010: header 0x0020 -> wire 20 00, data AA 00.
    we0 = we_a.size(); ab0 = n_abort;
    ss_start();
    spi_byte(8'h20, r0); spi_byte(8'h00, r0); spi_byte(8'hAA, r0); spi_byte(8'h00, r0);
    ss_end();
    chk("post_abt_count", we_a.size() - we0, 32'd1);
    chk("post_abt_addr",  {17'd0, we_a[we0]}, 32'h0010);
    chk("post_abt_data",  {16'd0, we_d[we0]}, 32'h00AA);
    chk("post_abt_abort", n_abort - ab0, 32'd0);

    // Reset mid-header, keep clocking through reset, then a clean write.
    we0 = we_a.size(); re0 = re_a.size(); ab0 = n_abort;
    ss_start();
    spi_byte(8'h04, r0); spi_bit(1'b0, rb); spi_bit(1'b0, rb); spi_bit(1'b0, rb);
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    chk("mrst_miso",  {31'd0, miso},    32'd0);
    chk("mrst_oe",    {31'd0, miso_oe}, 32'd0);
    chk("mrst_addr",  {17'd0, bus_addr},  32'd0);
    chk("mrst_wdata", {16'd0, bus_wdata}, 32'd0);
    chk("mrst_we",    {31'd0, bus_we},  32'd0);
    chk("mrst_re",    {31'd0, bus_re},  32'd0);
    chk("mrst_abort", {31'd0, abort},   32'd0);
    spi_bit(1'b0, rb); spi_bit(1'b0, rb);
    ss = 1'b1;
    repeat (4) @(negedge clk);
    resetn = 1'b1;
    repeat (6) @(negedge clk);
    chk("mrst_no_we",    we_a.size() - we0, 32'd0);
    chk("mrst_no_re",    re_a.size() - re0, 32'd0);
    chk("mrst_no_abort", n_abort - ab0, 32'd0);
    chk("mrst_wdata_after", {16'd0, bus_wdata}, 32'd0);
    ss_start();
    spi_byte(8'h04, r0); spi_byte(8'h00, r0); spi_byte(8'h55, r0); spi_byte(8'h55, r0);
    ss_end();
    chk("mrst_wr_count", we_a.size() - we0, 32'd1);
    chk("mrst_wr_addr",  {17'd0, we_a[we0]}, 32'h0002);
    chk("mrst_wr_data",  {16'd0, we_d[we0]}, 32'h5555);
    chk("mrst_wr_abort", n_abort - ab0, 32'd0);

    chk("we_re_overlap", n_both, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
